// File: rtl/reg_read_bypass_pkg.sv
// Shared definitions for the register-read/bypass stage: stage states and tag-width derivation.
package reg_read_bypass_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        VALID = 2'd2
    } stageState_t;

    // A single-entry file still needs a one-bit tag.
    function automatic int calcLogPhys(input int numRegs);
        return (numRegs > 1) ? $clog2(numRegs) : 1;
    endfunction

endpackage

// File: rtl/reg_read_bypass_PhysRegFileMP.sv
// Physical register file with ready-bit scoreboard: async read ports, prioritized write ports, alloc port.
module reg_read_bypass_PhysRegFileMP
    import reg_read_bypass_pkg::*;
#(
    parameter int NUM_PHYS_REGS = 64,
    parameter int DATA_WIDTH    = 32,
    parameter int NUM_SRC       = 3,
    parameter int NUM_WR        = 2,
    localparam int LOG_PHYS     = calcLogPhys(NUM_PHYS_REGS)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_SRC*LOG_PHYS-1:0]    rdTag,
    output logic [NUM_SRC*DATA_WIDTH-1:0]  rdData,
    output logic [NUM_SRC-1:0]             rdReady,
    input  logic [NUM_WR-1:0]              wrValid,
    input  logic [NUM_WR*LOG_PHYS-1:0]     wrTag,
    input  logic [NUM_WR*DATA_WIDTH-1:0]   wrData,
    input  logic                           allocValid,
    input  logic [LOG_PHYS-1:0]            allocTag
);

    logic [DATA_WIDTH-1:0]    regs [NUM_PHYS_REGS];
    logic [NUM_PHYS_REGS-1:0] readyBits;

    // Later ports overwrite earlier ones; alloc clears ready after any same-cycle write sets it.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NUM_PHYS_REGS; r++) begin
                regs[r] <= '0;
            end
            readyBits <= '1;
        end else begin
            for (int w = 0; w < NUM_WR; w++) begin
                if (wrValid[w]) begin
                    regs[wrTag[w*LOG_PHYS +: LOG_PHYS]]      <= wrData[w*DATA_WIDTH +: DATA_WIDTH];
                    readyBits[wrTag[w*LOG_PHYS +: LOG_PHYS]] <= 1'b1;
                end
            end
            if (allocValid) begin
                readyBits[allocTag] <= 1'b0;
            end
        end
    end

    always_comb begin
        rdData  = '0;
        rdReady = '0;
        for (int s = 0; s < NUM_SRC; s++) begin
            rdData[s*DATA_WIDTH +: DATA_WIDTH] = regs[rdTag[s*LOG_PHYS +: LOG_PHYS]];
            rdReady[s]                         = readyBits[rdTag[s*LOG_PHYS +: LOG_PHYS]];
        end
    end

endmodule

// File: rtl/reg_read_bypass.sv
// Register-read stage: captures source operands from the register file or writeback bypass, then hands off downstream.
module reg_read_bypass
    import reg_read_bypass_pkg::*;
#(
    parameter int NUM_PHYS_REGS = 64,
    parameter int DATA_WIDTH    = 32,
    parameter int NUM_SRC       = 3,
    parameter int NUM_WR        = 2,
    parameter int PAYLOAD_WIDTH = 64,
    localparam int LOG_PHYS     = calcLogPhys(NUM_PHYS_REGS)
) (
    input  logic                           CLK,
    input  logic                           RESET,
    input  logic                           FLUSH,
    input  logic                           IN_VALID,
    output logic                           IN_READY,
    input  logic [NUM_SRC*LOG_PHYS-1:0]    IN_SRC_TAG,
    input  logic [NUM_SRC-1:0]             IN_SRC_USE,
    input  logic [PAYLOAD_WIDTH-1:0]       IN_PAYLOAD,
    input  logic                           ALLOC_VALID,
    input  logic [LOG_PHYS-1:0]            ALLOC_TAG,
    input  logic [NUM_WR-1:0]              WR_VALID,
    input  logic [NUM_WR*LOG_PHYS-1:0]     WR_TAG,
    input  logic [NUM_WR*DATA_WIDTH-1:0]   WR_DATA,
    output logic                           OUT_VALID,
    input  logic                           OUT_READY,
    output logic [NUM_SRC*DATA_WIDTH-1:0]  OUT_SRC_VAL,
    output logic [PAYLOAD_WIDTH-1:0]       OUT_PAYLOAD
);

    stageState_t                   state_p1;
    logic                          vld_p1;
    logic [NUM_SRC*DATA_WIDTH-1:0] srcVal_p1;
    logic [NUM_SRC*LOG_PHYS-1:0]   srcTag_p1;
    logic [PAYLOAD_WIDTH-1:0]      payload_p1;
    logic [NUM_SRC-1:0]            captured_p1;

    logic [NUM_SRC*DATA_WIDTH-1:0] rdData;
    logic [NUM_SRC-1:0]            rdReady;
    logic [DATA_WIDTH:0]           inByp   [NUM_SRC];
    logic [DATA_WIDTH:0]           heldByp [NUM_SRC];
    logic [NUM_SRC-1:0]            inCap;
    logic [NUM_SRC-1:0]            waitCap;
    logic [NUM_SRC*DATA_WIDTH-1:0] inVal;
    logic                          accept;

    // Returns {hit, data}; the highest-index matching port wins, mirroring the register file.
    function automatic logic [DATA_WIDTH:0] wrBypass(
        input logic [LOG_PHYS-1:0]          tag,
        input logic [NUM_WR-1:0]            wv,
        input logic [NUM_WR*LOG_PHYS-1:0]   wt,
        input logic [NUM_WR*DATA_WIDTH-1:0] wd
    );
        logic [DATA_WIDTH:0] res;
        res = '0;
        for (int w = 0; w < NUM_WR; w++) begin
            if (wv[w] && (wt[w*LOG_PHYS +: LOG_PHYS] == tag)) begin
                res = {1'b1, wd[w*DATA_WIDTH +: DATA_WIDTH]};
            end
        end
        return res;
    endfunction

    reg_read_bypass_PhysRegFileMP #(
        .NUM_PHYS_REGS (NUM_PHYS_REGS),
        .DATA_WIDTH    (DATA_WIDTH),
        .NUM_SRC       (NUM_SRC),
        .NUM_WR        (NUM_WR)
    ) u_prf (
        .clk        (CLK),
        .reset      (RESET),
        .rdTag      (IN_SRC_TAG),
        .rdData     (rdData),
        .rdReady    (rdReady),
        .wrValid    (WR_VALID),
        .wrTag      (WR_TAG),
        .wrData     (WR_DATA),
        .allocValid (ALLOC_VALID),
        .allocTag   (ALLOC_TAG)
    );

    assign IN_READY = !FLUSH && ((state_p1 == IDLE) || ((state_p1 == VALID) && OUT_READY));
    assign accept   = IN_VALID && IN_READY;

    // Bypass is preferred over the stored value so a same-cycle writeback always supplies the newest data.
    always_comb begin
        inCap   = '0;
        waitCap = '0;
        inVal   = '0;
        for (int s = 0; s < NUM_SRC; s++) begin
            inByp[s]   = wrBypass(IN_SRC_TAG[s*LOG_PHYS +: LOG_PHYS], WR_VALID, WR_TAG, WR_DATA);
            heldByp[s] = wrBypass(srcTag_p1[s*LOG_PHYS +: LOG_PHYS], WR_VALID, WR_TAG, WR_DATA);
            inCap[s]   = !IN_SRC_USE[s] || inByp[s][DATA_WIDTH] || rdReady[s];
            waitCap[s] = captured_p1[s] || heldByp[s][DATA_WIDTH];
            if (IN_SRC_USE[s]) begin
                if (inByp[s][DATA_WIDTH]) begin
                    inVal[s*DATA_WIDTH +: DATA_WIDTH] = inByp[s][DATA_WIDTH-1:0];
                end else if (rdReady[s]) begin
                    inVal[s*DATA_WIDTH +: DATA_WIDTH] = rdData[s*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    // Stage p1: holds the instruction being read until all operands are captured and consumed.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_p1    <= IDLE;
            vld_p1      <= 1'b0;
            srcVal_p1   <= '0;
            srcTag_p1   <= '0;
            payload_p1  <= '0;
            captured_p1 <= '0;
        end else if (FLUSH) begin
            state_p1    <= IDLE;
            vld_p1      <= 1'b0;
            captured_p1 <= '0;
        end else begin
            case (state_p1)
                IDLE, VALID: begin
                    if (accept) begin
                        srcTag_p1   <= IN_SRC_TAG;
                        payload_p1  <= IN_PAYLOAD;
                        srcVal_p1   <= inVal;
                        captured_p1 <= inCap;
                        state_p1    <= (&inCap) ? VALID : WAIT;
                        vld_p1      <= &inCap;
                    end else if ((state_p1 == VALID) && OUT_READY) begin
                        state_p1    <= IDLE;
                        vld_p1      <= 1'b0;
                        captured_p1 <= '0;
                    end
                end
                WAIT: begin
                    for (int s = 0; s < NUM_SRC; s++) begin
                        if (!captured_p1[s] && heldByp[s][DATA_WIDTH]) begin
                            srcVal_p1[s*DATA_WIDTH +: DATA_WIDTH] <= heldByp[s][DATA_WIDTH-1:0];
                        end
                    end
                    captured_p1 <= waitCap;
                    if (&waitCap) begin
                        state_p1 <= VALID;
                        vld_p1   <= 1'b1;
                    end
                end
                default: begin
                    state_p1 <= IDLE;
                    vld_p1   <= 1'b0;
                end
            endcase
        end
    end

    assign OUT_VALID   = vld_p1;
    assign OUT_SRC_VAL = srcVal_p1;
    assign OUT_PAYLOAD = payload_p1;

endmodule

// File: tb/tb_reg_read_bypass.sv
// Directed self-checking bench for reg_read_bypass with default parameters.
module tb_reg_read_bypass;

    localparam int LP = 6;

    logic         clk = 1'b0;
    logic         RESET, FLUSH, IN_VALID, IN_READY, ALLOC_VALID, OUT_VALID, OUT_READY;
    logic [17:0]  IN_SRC_TAG;
    logic [2:0]   IN_SRC_USE;
    logic [63:0]  IN_PAYLOAD, OUT_PAYLOAD;
    logic [5:0]   ALLOC_TAG;
    logic [1:0]   WR_VALID;
    logic [11:0]  WR_TAG;
    logic [63:0]  WR_DATA;
    logic [95:0]  OUT_SRC_VAL;

    int testCnt = 0;
    int failCnt = 0;

    reg_read_bypass dut (
        .CLK         (clk),
        .RESET       (RESET),
        .FLUSH       (FLUSH),
        .IN_VALID    (IN_VALID),
        .IN_READY    (IN_READY),
        .IN_SRC_TAG  (IN_SRC_TAG),
        .IN_SRC_USE  (IN_SRC_USE),
        .IN_PAYLOAD  (IN_PAYLOAD),
        .ALLOC_VALID (ALLOC_VALID),
        .ALLOC_TAG   (ALLOC_TAG),
        .WR_VALID    (WR_VALID),
        .WR_TAG      (WR_TAG),
        .WR_DATA     (WR_DATA),
        .OUT_VALID   (OUT_VALID),
        .OUT_READY   (OUT_READY),
        .OUT_SRC_VAL (OUT_SRC_VAL),
        .OUT_PAYLOAD (OUT_PAYLOAD)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        testCnt++;
        assert (obs === exp) else begin
            failCnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [17:0] tags3(input logic [5:0] t0, input logic [5:0] t1, input logic [5:0] t2);
        return {t2, t1, t0};
    endfunction

    task automatic issue(input logic [17:0] tags, input logic [2:0] use_, input logic [63:0] pl);
        IN_VALID   = 1'b1;
        IN_SRC_TAG = tags;
        IN_SRC_USE = use_;
        IN_PAYLOAD = pl;
    endtask

    task automatic idleInputs();
        IN_VALID    = 1'b0;
        ALLOC_VALID = 1'b0;
        WR_VALID    = 2'b00;
    endtask

    initial begin
        RESET = 1'b1; FLUSH = 1'b0; OUT_READY = 1'b1;
        IN_VALID = 1'b0; IN_SRC_TAG = '0; IN_SRC_USE = '0; IN_PAYLOAD = '0;
        ALLOC_VALID = 1'b0; ALLOC_TAG = '0; WR_VALID = '0; WR_TAG = '0; WR_DATA = '0;
        tick(); tick();
        RESET = 1'b0;
        chk("rst_out_valid", OUT_VALID, 1'b0);
        chk("rst_in_ready", IN_READY, 1'b1);
        chk("rst_src_val", OUT_SRC_VAL, 96'h0);
        chk("rst_payload", OUT_PAYLOAD, 64'h0);

        // Basic read of ready tags; unused operand points at a non-zero tag but must read 0.
        WR_VALID = 2'b11; WR_TAG = {6'd9, 6'd5}; WR_DATA = {32'hBEEF, 32'h1234};
        tick();
        idleInputs();
        issue(tags3(6'd5, 6'd9, 6'd5), 3'b011, 64'hA1);
        tick();
        idleInputs();
        chk("basic_valid", OUT_VALID, 1'b1);
        chk("basic_vals", OUT_SRC_VAL, {32'h0, 32'hBEEF, 32'h1234});
        chk("basic_payload", OUT_PAYLOAD, 64'hA1);
        tick();
        chk("basic_drain", OUT_VALID, 1'b0);

        // Wait on an allocated tag, then wake up on its writeback.
        ALLOC_VALID = 1'b1; ALLOC_TAG = 6'd7;
        tick();
        idleInputs();
        issue(tags3(6'd7, 6'd0, 6'd0), 3'b001, 64'hB2);
        tick();
        idleInputs();
        for (int i = 0; i < 3; i++) begin
            chk("wait_out_valid", OUT_VALID, 1'b0);
            chk("wait_in_ready", IN_READY, 1'b0);
            tick();
        end
        WR_VALID = 2'b01; WR_TAG = {6'd0, 6'd7}; WR_DATA = {32'h0, 32'hCAFE};
        tick();
        idleInputs();
        chk("wake_valid", OUT_VALID, 1'b1);
        chk("wake_src0", OUT_SRC_VAL[31:0], 32'hCAFE);
        chk("wake_payload", OUT_PAYLOAD, 64'hB2);
        tick();

        // Same-cycle alloc and accept: operand sees the pre-allocation ready bit (tag 20 holds 0).
        ALLOC_VALID = 1'b1; ALLOC_TAG = 6'd20;
        issue(tags3(6'd20, 6'd0, 6'd0), 3'b001, 64'hB3);
        tick();
        idleInputs();
        chk("alloc_same_cycle_valid", OUT_VALID, 1'b1);
        chk("alloc_same_cycle_val", OUT_SRC_VAL[31:0], 32'h0);
        tick();

        // Bypass from write port 1 on the accept cycle.
        ALLOC_VALID = 1'b1; ALLOC_TAG = 6'd12;
        tick();
        idleInputs();
        issue(tags3(6'd12, 6'd0, 6'd0), 3'b001, 64'hC0);
        WR_VALID = 2'b10; WR_TAG = {6'd12, 6'd0}; WR_DATA = {32'h55, 32'h0};
        tick();
        idleInputs();
        chk("bypass_valid", OUT_VALID, 1'b1);
        chk("bypass_val", OUT_SRC_VAL[31:0], 32'h55);
        tick();

        // Both ports write tag 3: port 1 wins in storage.
        WR_VALID = 2'b11; WR_TAG = {6'd3, 6'd3}; WR_DATA = {32'h22, 32'h11};
        tick();
        idleInputs();
        issue(tags3(6'd0, 6'd3, 6'd0), 3'b010, 64'hC1);
        tick();
        idleInputs();
        chk("dual_wr_storage", OUT_SRC_VAL[63:32], 32'h22);
        tick();

        // Both ports write a waiting tag on the accept cycle: port 1 wins in the bypass too.
        ALLOC_VALID = 1'b1; ALLOC_TAG = 6'd4;
        tick();
        idleInputs();
        issue(tags3(6'd4, 6'd0, 6'd0), 3'b001, 64'hC2);
        WR_VALID = 2'b11; WR_TAG = {6'd4, 6'd4}; WR_DATA = {32'h44, 32'h33};
        tick();
        idleInputs();
        chk("dual_wr_bypass", OUT_SRC_VAL[31:0], 32'h44);
        tick();

        // Backpressure: hold four cycles, then drain back-to-back.
        OUT_READY = 1'b0;
        issue(tags3(6'd5, 6'd0, 6'd0), 3'b001, 64'hD1);
        tick();
        issue(tags3(6'd9, 6'd0, 6'd0), 3'b001, 64'hD2);
        for (int i = 0; i < 4; i++) begin
            chk("stall_valid", OUT_VALID, 1'b1);
            chk("stall_payload", OUT_PAYLOAD, 64'hD1);
            chk("stall_val", OUT_SRC_VAL[31:0], 32'h1234);
            chk("stall_in_ready", IN_READY, 1'b0);
            tick();
        end
        OUT_READY = 1'b1;
        #1;
        chk("release_in_ready", IN_READY, 1'b1);
        tick();
        chk("b2b_1_payload", OUT_PAYLOAD, 64'hD2);
        chk("b2b_1_val", OUT_SRC_VAL[31:0], 32'hBEEF);
        issue(tags3(6'd3, 6'd0, 6'd0), 3'b001, 64'hD3);
        tick();
        idleInputs();
        chk("b2b_2_valid", OUT_VALID, 1'b1);
        chk("b2b_2_payload", OUT_PAYLOAD, 64'hD3);
        chk("b2b_2_val", OUT_SRC_VAL[31:0], 32'h22);
        tick();
        chk("b2b_drain", OUT_VALID, 1'b0);

        // Flush during WAIT drops the instruction for good.
        ALLOC_VALID = 1'b1; ALLOC_TAG = 6'd30;
        tick();
        idleInputs();
        issue(tags3(6'd30, 6'd0, 6'd0), 3'b001, 64'hE1);
        tick();
        idleInputs();
        chk("flush_pre_wait", OUT_VALID, 1'b0);
        FLUSH = 1'b1;
        tick();
        FLUSH = 1'b0;
        #1;
        chk("flush_out_valid", OUT_VALID, 1'b0);
        chk("flush_idle_ready", IN_READY, 1'b1);
        WR_VALID = 2'b01; WR_TAG = {6'd0, 6'd30}; WR_DATA = {32'h0, 32'h77};
        tick();
        idleInputs();
        chk("flush_no_out_1", OUT_VALID, 1'b0);
        tick();
        chk("flush_no_out_2", OUT_VALID, 1'b0);

        // Flush overrides an accept and blocks IN_READY.
        FLUSH = 1'b1;
        issue(tags3(6'd5, 6'd0, 6'd0), 3'b001, 64'hE2);
        #1;
        chk("flush_in_ready", IN_READY, 1'b0);
        tick();
        FLUSH = 1'b0;
        idleInputs();
        chk("flush_no_accept", OUT_VALID, 1'b0);

        $display("[TB] %0d tests run, %0d failed", testCnt, failCnt);
        $finish;
    end

endmodule
